pio_vga_pin_stage: RTL and testbench
====================================

Name: pio_vga_pin_stage

Overview:
Parametrised output/input pin stage between the pixel core and the chip pins. It reduces RGB colour depth with ordered 2x2 Bayer dithering and forces blanking. It applies the configured sync polarity, and pipelines pixel, sync and PIO-RAM tx pins with equal latency. It also synchronises the PIO-RAM rx pins through a configurable flop chain. It is the next generation of the fixed 4-bit-to-2-bit TinyVGA output register stage.

Parameters:
IN_BITS, 4, colour bits per channel from the core
OUT_BITS, 2, colour bits per channel to the pins; IN_BITS-OUT_BITS must be >= 2
IO_BITS, 2, PIO-RAM tx/rx pin count
OUT_PIPE, 1, output register stages, legal range 1..3
RX_SYNC_STAGES, 2, rx synchroniser depth, legal range 1..3
SYNC_NEG, 1, 1 = sync pins active-low

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rgb_in  in  3*IN_BITS  {r,g,b}, r in the MSBs
de  in  1  display enable (active video)
hsync  in  1  active-high hsync from the core
vsync  in  1  active-high vsync from the core
new_frame  in  1  one-cycle pulse per frame
tx_in  in  IO_BITS  PIO-RAM tx from the core
rx_pins  in  IO_BITS  raw rx pins (asynchronous)
pix_out  out  3*OUT_BITS  dithered {r,g,b}
hsync_out  out  1  hsync at pin polarity
vsync_out  out  1  vsync at pin polarity
tx_out  out  IO_BITS  registered tx pins
rx_out  out  IO_BITS  synchronised rx to the core

Behaviour:
- Reset (async assert, sync release):
  - pix_out = 0, tx_out = 0, rx_out = 0.
  - hsync_out/vsync_out = inactive level (SYNC_NEG ? 1 : 0).
  - All pipe and synchroniser flops and all counters = 0.
- Position phase, updated on each clk:
  - x_ph toggles every cycle with de=1; cleared when de=0.
  - y_ph toggles on the falling edge of de (a registered de_d is required); cleared while vsync=1.
  - If vsync=1 and de falls in the same cycle, the clear wins.
  - frame_ct, 2 bits, increments on new_frame and wraps 3->0. Not used unless the optional feature is compiled in.
- Dither, combinational and per channel; let D = IN_BITS-OUT_BITS.
  - hi = c[IN_BITS-1:D], lo = c[D-1:0].
  - Bayer index B[y][x]: B[0][0]=0, B[0][1]=2, B[1][0]=3, B[1][1]=1.
  - thr = B[y_ph][x_ph] << (D-2).
  - out = hi + (lo > thr), saturating at all-ones (no wrap).
  - de=0 forces out = 0 on all channels.
- Sync: hsync_out = hsync ^ SYNC_NEG, and likewise for vsync_out.
- Latency: pix_out, hsync_out, vsync_out and tx_out appear exactly OUT_PIPE cycles after the inputs are sampled. All four paths are always aligned; there is no combinational path from input to output.
- rx: rx_out = rx_pins delayed through RX_SYNC_STAGES flops. There is no other logic on this path.
- Reset mid-line: all outputs go to their reset values immediately. The phase counters restart at 0, and the first de cycle after release uses x_ph=0, y_ph=0.
- Illegal parameters (D<2, OUT_PIPE or RX_SYNC_STAGES out of range) are rejected by an elaboration-time check (generate-if with an $error).

Optional Feature:
DITHER_TEMPORAL_EN
- Defined: the Bayer index is read at B[y_ph^frame_ct[1]][x_ph^frame_ct[0]], so the pattern rotates every frame.
- Undefined: the pattern is static. frame_ct is removed and new_frame is unused, tied into the unused-sink.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> pix_out=0, hsync_out=vsync_out=1 (SYNC_NEG=1), tx_out=0, rx_out=0; deassert -> outputs change only after OUT_PIPE clocks.
- Defaults, vsync pulse, then de=1 with rgb_in=12'h5A3 on the first pixel (x=0, y=0, thr=0) -> pix_out={2'd2,2'd3,2'd1} after 1 cycle.
- Same line, second pixel (x_ph=1, thr=2), rgb_in=12'h5A3 -> r: lo=1 gives 1, g: lo=2 gives 2, b: lo=3 gives 1, so pix_out={2'd1,2'd2,2'd1}.
- Saturation and blanking: rgb_in=12'hFFF at x=0, y=0 -> pix_out=6'h3F (no wrap); drop de -> pix_out=0 on the next output cycle.
- Line phase and alignment, OUT_PIPE=3: after one de fall, a pixel at x=0 uses thr=3, so rgb_in=12'h333 gives 0 per channel; hsync, tx_in=2'b10 and pix all emerge together 3 cycles later.
- rx synchroniser, RX_SYNC_STAGES=2: step rx_pins 0->3 -> rx_out=3 exactly 2 clocks later. With DITHER_TEMPORAL_EN, pulse new_frame once -> the pixel at x=0, y=0 uses thr=2.

Source files
------------

// File: rtl/pio_vga_pin_stage_if.sv
// Pin-stage bus between the pixel core and the chip pins.
// master = core side driving pixels/sync/tx, slave = pin stage.
interface pio_vga_pin_stage_if #(
    parameter int IN_BITS  = 4,
    parameter int OUT_BITS = 2,
    parameter int IO_BITS  = 2
);
    logic [3*IN_BITS-1:0]  rgb_in;
    logic                  de;
    logic                  hsync;
    logic                  vsync;
    logic                  new_frame;
    logic [IO_BITS-1:0]    tx_in;
    logic [IO_BITS-1:0]    rx_pins;
    logic [3*OUT_BITS-1:0] pix_out;
    logic                  hsync_out;
    logic                  vsync_out;
    logic [IO_BITS-1:0]    tx_out;
    logic [IO_BITS-1:0]    rx_out;

    modport master (
        output rgb_in, de, hsync, vsync, new_frame, tx_in, rx_pins,
        input  pix_out, hsync_out, vsync_out, tx_out, rx_out
    );

    modport slave (
        input  rgb_in, de, hsync, vsync, new_frame, tx_in, rx_pins,
        output pix_out, hsync_out, vsync_out, tx_out, rx_out
    );
endinterface

// File: rtl/pio_vga_pin_stage.sv
// VGA pin stage: 2x2 Bayer dither, blanking, sync polarity, aligned pipes.
// Optional DITHER_TEMPORAL_EN rotates the Bayer pattern every frame.
module pio_vga_pin_stage #(
    parameter int IN_BITS        = 4,
    parameter int OUT_BITS       = 2,
    parameter int IO_BITS        = 2,
    parameter int OUT_PIPE       = 1,
    parameter int RX_SYNC_STAGES = 2,
    parameter bit SYNC_NEG       = 1'b1
) (
    input logic clk,
    input logic rst_n,
    pio_vga_pin_stage_if.slave bus
);
    localparam int D  = IN_BITS - OUT_BITS;
    localparam int PW = 3*OUT_BITS + 2 + IO_BITS;
    localparam logic [PW-1:0] RST_VEC =
        PW'({SYNC_NEG, SYNC_NEG}) << IO_BITS;

    generate
        if (D < 2) begin : g_bad_depth
            $error("IN_BITS-OUT_BITS must be >= 2");
        end
        if (OUT_PIPE < 1 || OUT_PIPE > 3) begin : g_bad_pipe
            $error("OUT_PIPE must be 1..3");
        end
        if (RX_SYNC_STAGES < 1 || RX_SYNC_STAGES > 3) begin : g_bad_rx
            $error("RX_SYNC_STAGES must be 1..3");
        end
    endgenerate

    logic x_ph;
    logic y_ph;
    logic de_d;
    logic bx;
    logic by;

    logic [1:0]            bidx;
    logic [3*OUT_BITS-1:0] pix_c;
    logic [PW-1:0]         stg_in;
    logic [PW-1:0]         pipe [OUT_PIPE];
    logic [IO_BITS-1:0]    rx_q [RX_SYNC_STAGES];

    function automatic logic [1:0] bayer(input logic y, input logic x);
        logic [1:0] v;
        unique case ({y, x})
            2'b00:   v = 2'd0;
            2'b01:   v = 2'd2;
            2'b10:   v = 2'd3;
            default: v = 2'd1;
        endcase
        return v;
    endfunction

    function automatic logic [OUT_BITS-1:0] dither(
        input logic [IN_BITS-1:0] c,
        input logic [1:0]         b
    );
        logic [OUT_BITS-1:0] hi;
        logic [D-1:0]        lo;
        logic [D-1:0]        thr;
        logic [OUT_BITS:0]   sum;
        hi  = c[IN_BITS-1:D];
        lo  = c[D-1:0];
        thr = D'(b) << (D - 2);
        sum = {1'b0, hi} + {{OUT_BITS{1'b0}}, (lo > thr)};
        if (sum[OUT_BITS]) begin
            return '1;
        end
        return sum[OUT_BITS-1:0];
    endfunction

    // Screen phase: x parity within a de run, y parity across lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_ph <= 1'b0;
            y_ph <= 1'b0;
            de_d <= 1'b0;
        end else begin
            de_d <= bus.de;
            x_ph <= bus.de ? ~x_ph : 1'b0;
            if (bus.vsync) begin
                y_ph <= 1'b0;
            end else if (de_d && !bus.de) begin
                y_ph <= ~y_ph;
            end
        end
    end

`ifdef DITHER_TEMPORAL_EN
    logic [1:0] frame_ct;

    // Frame counter rotates the Bayer pattern each frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ct <= 2'd0;
        end else if (bus.new_frame) begin
            frame_ct <= frame_ct + 2'd1;
        end
    end

    assign bx = x_ph ^ frame_ct[0];
    assign by = y_ph ^ frame_ct[1];
`else
    logic unused_sink;
    assign unused_sink = bus.new_frame;
    assign bx = x_ph;
    assign by = y_ph;
`endif

    assign bidx = bayer(by, bx);

    // Per-channel dither with blanking outside active video.
    always_comb begin
        pix_c = '0;
        if (bus.de) begin
            pix_c = {
                dither(bus.rgb_in[3*IN_BITS-1 -: IN_BITS], bidx),
                dither(bus.rgb_in[2*IN_BITS-1 -: IN_BITS], bidx),
                dither(bus.rgb_in[IN_BITS-1   -: IN_BITS], bidx)
            };
        end
    end

    assign stg_in = {
        pix_c,
        bus.hsync ^ SYNC_NEG,
        bus.vsync ^ SYNC_NEG,
        bus.tx_in
    };

    // Output pipe: pixel, sync and tx travel together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_PIPE; i++) begin
                pipe[i] <= RST_VEC;
            end
        end else begin
            pipe[0] <= stg_in;
            for (int i = 1; i < OUT_PIPE; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign {bus.pix_out, bus.hsync_out, bus.vsync_out, bus.tx_out} =
        pipe[OUT_PIPE-1];

    // rx synchroniser chain for the asynchronous PIO-RAM pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RX_SYNC_STAGES; i++) begin
                rx_q[i] <= '0;
            end
        end else begin
            rx_q[0] <= bus.rx_pins;
            for (int i = 1; i < RX_SYNC_STAGES; i++) begin
                rx_q[i] <= rx_q[i-1];
            end
        end
    end

    assign bus.rx_out = rx_q[RX_SYNC_STAGES-1];

endmodule

// File: tb/tb_pio_vga_pin_stage.sv
// Bench for pio_vga_pin_stage: two instances (pipe 1/rx 2, pipe 3/rx 3)
// checked against a position-counting reference model.
module tb_pio_vga_pin_stage;
    localparam int IN_BITS  = 4;
    localparam int OUT_BITS = 2;
    localparam int IO_BITS  = 2;
    localparam int PW       = 3*OUT_BITS + 2 + IO_BITS;
    localparam bit SYNC_NEG = 1'b1;
    localparam logic [PW-1:0] RST_VEC = {6'd0, SYNC_NEG, SYNC_NEG, 2'd0};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [11:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        nf;
    logic [1:0]  tx;
    logic [1:0]  rxp;

    pio_vga_pin_stage_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS),
                           .IO_BITS(IO_BITS)) b1 ();
    pio_vga_pin_stage_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS),
                           .IO_BITS(IO_BITS)) b3 ();

    assign b1.rgb_in = rgb;  assign b3.rgb_in = rgb;
    assign b1.de = de;       assign b3.de = de;
    assign b1.hsync = hs;    assign b3.hsync = hs;
    assign b1.vsync = vs;    assign b3.vsync = vs;
    assign b1.new_frame = nf; assign b3.new_frame = nf;
    assign b1.tx_in = tx;    assign b3.tx_in = tx;
    assign b1.rx_pins = rxp; assign b3.rx_pins = rxp;

    pio_vga_pin_stage #(
        .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .IO_BITS(IO_BITS),
        .OUT_PIPE(1), .RX_SYNC_STAGES(2), .SYNC_NEG(SYNC_NEG)
    ) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    pio_vga_pin_stage #(
        .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .IO_BITS(IO_BITS),
        .OUT_PIPE(3), .RX_SYNC_STAGES(3), .SYNC_NEG(SYNC_NEG)
    ) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    wire [PW-1:0] o1 = {b1.pix_out, b1.hsync_out, b1.vsync_out, b1.tx_out};
    wire [PW-1:0] o3 = {b3.pix_out, b3.hsync_out, b3.vsync_out, b3.tx_out};

    int checks   = 0;
    int failures = 0;

    // Reference model state: screen position in plain counts.
    int run_len = 0;
    int lines   = 0;
    int frames  = 0;
    bit prev_de = 1'b0;
    int bay [2][2] = '{'{0, 2}, '{3, 1}};
    logic [PW-1:0] vh [$];
    logic [1:0]    rh [$];

    task automatic chk(input string tag, input logic [PW-1:0] got,
                       input logic [PW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dith_ch(int c, int bi);
        int d;
        int hi;
        int lo;
        int thr;
        int o;
        int mx;
        d   = IN_BITS - OUT_BITS;
        hi  = c / (1 << d);
        lo  = c % (1 << d);
        thr = bi * (1 << (d - 2));
        o   = hi + ((lo > thr) ? 1 : 0);
        mx  = (1 << OUT_BITS) - 1;
        return (o > mx) ? mx : o;
    endfunction

    function automatic logic [PW-1:0] model_vec();
        int x;
        int y;
        int bi;
        int pix;
        x = run_len % 2;
        y = lines % 2;
`ifdef DITHER_TEMPORAL_EN
        x = x ^ (frames % 2);
        y = y ^ ((frames / 2) % 2);
`endif
        bi  = bay[y][x];
        pix = 0;
        if (de) begin
            pix = dith_ch(int'(rgb[11:8]), bi) * 16
                + dith_ch(int'(rgb[7:4]), bi) * 4
                + dith_ch(int'(rgb[3:0]), bi);
        end
        return {6'(pix), hs ^ SYNC_NEG, vs ^ SYNC_NEG, tx};
    endfunction

    function automatic logic [PW-1:0] exp_vec(int k);
        return (vh.size() >= k) ? vh[k-1] : RST_VEC;
    endfunction

    function automatic logic [1:0] exp_rx(int k);
        return (rh.size() >= k) ? rh[k-1] : 2'd0;
    endfunction

    // One clock with the currently driven inputs, then check all outputs.
    task automatic cycle();
        logic [PW-1:0] e;
        e = model_vec();
        @(posedge clk);
        vh.push_front(e);
        rh.push_front(rxp);
        if (vh.size() > 8) void'(vh.pop_back());
        if (rh.size() > 8) void'(rh.pop_back());
        if (nf) frames = (frames + 1) % 4;
        if (vs) lines = 0;
        else if (prev_de && !de) lines++;
        run_len = de ? run_len + 1 : 0;
        prev_de = de;
        @(negedge clk);
        chk("pipe1", o1, exp_vec(1));
        chk("pipe3", o3, exp_vec(3));
        chk("rx2", PW'(b1.rx_out), PW'(exp_rx(2)));
        chk("rx3", PW'(b3.rx_out), PW'(exp_rx(3)));
    endtask

    task automatic rand_in();
        rgb = 12'($urandom);
        if ($urandom_range(0, 3) == 0) de = ~de;
        hs  = ($urandom_range(0, 7) == 0);
        vs  = ($urandom_range(0, 19) == 0);
        nf  = ($urandom_range(0, 29) == 0);
        tx  = 2'($urandom);
        rxp = 2'($urandom);
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_o1"}, o1, RST_VEC);
        chk({tag, "_o3"}, o3, RST_VEC);
        chk({tag, "_rx1"}, PW'(b1.rx_out), '0);
        chk({tag, "_rx3"}, PW'(b3.rx_out), '0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        chk_rst("rst_now");
        vh.delete();
        rh.delete();
        run_len = 0;
        lines   = 0;
        frames  = 0;
        prev_de = 1'b0;
        repeat (n) begin
            rand_in();
            @(posedge clk);
            @(negedge clk);
            chk_rst("rst_hold");
        end
        rst_n = 1'b1;
    endtask

    task automatic idle_in();
        rgb = '0; de = 1'b0; hs = 1'b0; vs = 1'b0;
        nf = 1'b0; tx = '0; rxp = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        de = 1'b0;
        rand_in();
        #2;
        do_reset(3);

        idle_in();
        vs = 1'b1; cycle();
        vs = 1'b0; cycle();
        de = 1'b1; rgb = 12'h5A3; cycle();
        chk("px_x0y0", PW'(o1[9:4]), PW'(6'h2D));
        cycle();
        chk("px_x1y0", PW'(o1[9:4]), PW'(6'h19));

        de = 1'b0; vs = 1'b1; cycle();
        vs = 1'b0; de = 1'b1; rgb = 12'hFFF; cycle();
        chk("sat", PW'(o1[9:4]), PW'(6'h3F));
        de = 1'b0; cycle();
        chk("blank", PW'(o1[9:4]), '0);

        de = 1'b1; rgb = 12'h333; hs = 1'b1; tx = 2'b10; cycle();
        chk("line_ph", o1, PW'(10'b000000_0_1_10));
        de = 1'b0; hs = 1'b0; tx = 2'b00; cycle();
        chk("align_early", o3, RST_VEC);
        cycle();
        chk("align3", o3, PW'(10'b000000_0_1_10));

        rxp = 2'd0; cycle(); cycle();
        rxp = 2'd3; cycle();
        chk("rx_1clk", PW'(b1.rx_out), '0);
        cycle();
        chk("rx_2clk", PW'(b1.rx_out), PW'(2'd3));

        de = 1'b0; vs = 1'b1; nf = 1'b1; cycle();
        vs = 1'b0; nf = 1'b0; de = 1'b1; rgb = 12'h5A3; cycle();
`ifdef DITHER_TEMPORAL_EN
        chk("frame_rot", PW'(o1[9:4]), PW'(6'h19));
`else
        chk("frame_static", PW'(o1[9:4]), PW'(6'h2D));
`endif

        rgb = 12'h5A3; cycle();
        do_reset(1);
        idle_in();
        de = 1'b1; rgb = 12'h5A3; cycle();
        chk("rst_midline", PW'(o1[9:4]), PW'(6'h2D));

        repeat (800) begin
            rand_in();
            if ($urandom_range(0, 199) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
